// File: rtl/hazard_pkg.sv
// hazard_pkg: state encodings and per-stage enable/flush control words for hazard_ctrl.
package hazard_pkg;
    typedef enum logic [2:0] {RUN = 3'd0, DWAIT = 3'd1, IWAIT = 3'd2, HALTED = 3'd3, ERR = 3'd4} state_t;
    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic ifid_flush;
        logic idex_en;
        logic idex_flush;
        logic exmem_en;
        logic exmem_flush;
        logic memwb_en;
    } ctrl_t;
    // NOP-insert control words, one per pipeline situation
    localparam ctrl_t CTRL_ADV      = 8'b1101_0101;
    localparam ctrl_t CTRL_FREEZE   = 8'b0000_0000;
    localparam ctrl_t CTRL_BRANCH   = 8'b1111_1101;
    localparam ctrl_t CTRL_REDIR    = 8'b1001_1101;
    localparam ctrl_t CTRL_LOAD_USE = 8'b0000_0111;
    localparam ctrl_t CTRL_JUMP     = 8'b1111_0101;
    localparam ctrl_t CTRL_IWAIT    = 8'b0001_1101;
    localparam ctrl_t CTRL_HALT     = 8'b0000_0001;
endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: hazard inputs and stage control outputs between controller (master) and pipeline (slave).
interface hazard_ctrl_if;
    logic Need_Stall, Branch_Taken, Jump_ID, IMem_Ready, DMem_Req, DMem_Ready, Halt;
    logic PC_En, IFid_En, IFid_Flush, IDex_En, IDex_Flush, EXmem_En, EXmem_Flush, MEMwb_En;
    logic BubbleMA, Mem_Err;
    logic [2:0] State;
    modport master (
        input  Need_Stall, Branch_Taken, Jump_ID, IMem_Ready, DMem_Req, DMem_Ready, Halt,
        output PC_En, IFid_En, IFid_Flush, IDex_En, IDex_Flush, EXmem_En, EXmem_Flush, MEMwb_En,
        output BubbleMA, Mem_Err, State
    );
    modport slave (
        output Need_Stall, Branch_Taken, Jump_ID, IMem_Ready, DMem_Req, DMem_Ready, Halt,
        input  PC_En, IFid_En, IFid_Flush, IDex_En, IDex_Flush, EXmem_En, EXmem_Flush, MEMwb_En,
        input  BubbleMA, Mem_Err, State
    );
endinterface

// File: rtl/hazard_wait_timer.sv
// hazard_wait_timer: counts consecutive enabled cycles; timeout fires on the LIMIT-th one.
module hazard_wait_timer #(
    parameter int WAIT_W = 4,
    parameter int LIMIT  = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic timeout
);
    logic [WAIT_W-1:0] cnt;
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en) cnt <= cnt + 1'b1;
    assign timeout = en & (cnt == WAIT_W'(LIMIT - 1));
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush controller with BubbleMA flag and data-memory watchdog.
// Optional HAZARD_PERF_EN adds saturating stall/flush performance counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int WAIT_W      = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    hazard_ctrl_if.master bus
`ifdef HAZARD_PERF_EN
    ,
    input  logic        Perf_Clr,
    output logic [15:0] Stall_Cycles,
    output logic [15:0] Flush_Cnt
`endif
);
    state_t state, state_n;
    ctrl_t c;
    logic bubble, bub_n, mem_err, redirect_pend, pend_n, timeout;
    wire active = (state != HALTED) && (state != ERR);
    wire dwait  = bus.DMem_Req & ~bus.DMem_Ready;
    hazard_wait_timer #(.WAIT_W(WAIT_W), .LIMIT(MEM_TIMEOUT)) u_timer (
        .clk(clk), .rst(rst), .clr(~(active & dwait)), .en(active & dwait), .timeout(timeout)
    );
    always_comb begin
        c = CTRL_ADV;
        state_n = state;
        pend_n = redirect_pend;
        bub_n = bubble;
        if (!active) c = CTRL_FREEZE;
        else if (dwait) begin
            c = CTRL_FREEZE;
            state_n = timeout ? ERR : DWAIT;
        end else if (bus.Halt) begin
            c = CTRL_HALT;
            state_n = HALTED;
        end else begin
            state_n = bus.IMem_Ready ? RUN : IWAIT;
            bub_n = 1'b0;
            if (bus.Branch_Taken && bus.IMem_Ready) begin
                c = CTRL_BRANCH;
                pend_n = 1'b0;
            end else if (bus.Branch_Taken) begin
                c = CTRL_REDIR;
                pend_n = 1'b1;
            end else if (bus.Need_Stall) begin
                c = CTRL_LOAD_USE;
                bub_n = 1'b1;
            end else if (bus.Jump_ID) begin
                c = CTRL_JUMP;
                pend_n = redirect_pend & ~bus.IMem_Ready;
            end else if (!bus.IMem_Ready) c = CTRL_IWAIT;
            else begin
                c.ifid_flush = redirect_pend;
                pend_n = 1'b0;
            end
        end
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= RUN;
            bubble <= 1'b0;
            mem_err <= 1'b0;
            redirect_pend <= 1'b0;
        end else begin
            state <= state_n;
            bubble <= bub_n;
            mem_err <= mem_err | (state_n == ERR);
            redirect_pend <= pend_n;
        end
    assign bus.PC_En       = c.pc_en;
    assign bus.IFid_En     = c.ifid_en;
    assign bus.IFid_Flush  = c.ifid_flush;
    assign bus.IDex_En     = c.idex_en;
    assign bus.IDex_Flush  = c.idex_flush;
    assign bus.EXmem_En    = c.exmem_en;
    assign bus.EXmem_Flush = c.exmem_flush;
    assign bus.MEMwb_En    = c.memwb_en;
    assign bus.BubbleMA    = bubble;
    assign bus.Mem_Err     = mem_err;
    assign bus.State       = state;
`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            Stall_Cycles <= '0;
            Flush_Cnt <= '0;
        end else begin
            Stall_Cycles <= Perf_Clr ? '0 : Stall_Cycles + 16'((active && !c.pc_en && Stall_Cycles != 16'hFFFF) ? 1 : 0);
            Flush_Cnt <= Perf_Clr ? '0 : Flush_Cnt + 16'((c.ifid_flush && Flush_Cnt != 16'hFFFF) ? 1 : 0);
        end
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed stimulus with an in-bench rule model compared every cycle, plus literal checks.
module tb_hazard_ctrl;
    localparam int MEM_TIMEOUT = 15;
    logic clk = 1'b0, rst = 1'b1;
    int checks = 0, errors = 0;
    hazard_ctrl_if bus();
    hazard_ctrl #(.WAIT_W(4), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    // model state
    bit m_err, m_halt, m_pend, m_bub;
    int m_wcnt, m_st;
    logic e_pc, e_ifen, e_iffl, e_iden, e_idfl, e_exen, e_exfl, e_wben;

    always_comb begin
        {e_pc, e_ifen, e_iden, e_exen, e_wben} = 5'b11111;
        {e_iffl, e_idfl, e_exfl} = 3'b000;
        if (m_err || m_halt || (bus.DMem_Req && !bus.DMem_Ready))
            {e_pc, e_ifen, e_iden, e_exen, e_wben} = 5'b00000;
        else if (bus.Halt) {e_pc, e_ifen, e_iden, e_exen} = 4'b0000;
        else if (bus.Branch_Taken) begin
            e_idfl = 1'b1;
            if (bus.IMem_Ready) e_iffl = 1'b1;
            else e_ifen = 1'b0;
        end else if (bus.Need_Stall) begin
            {e_pc, e_ifen, e_iden} = 3'b000;
            e_exfl = 1'b1;
        end else if (bus.Jump_ID) e_iffl = 1'b1;
        else if (!bus.IMem_Ready) begin
            {e_pc, e_ifen} = 2'b00;
            e_idfl = 1'b1;
        end else e_iffl = m_pend;
    end

    always @(posedge clk or posedge rst)
        if (rst) begin
            {m_err, m_halt, m_pend, m_bub} = '0;
            m_wcnt = 0;
            m_st = 0;
        end else if (!m_err && !m_halt) begin
            if (bus.DMem_Req && !bus.DMem_Ready) begin
                m_wcnt++;
                m_err = (m_wcnt == MEM_TIMEOUT);
                m_st = m_err ? 4 : 1;
            end else begin
                m_wcnt = 0;
                if (bus.Halt) begin
                    m_halt = 1;
                    m_st = 3;
                end else m_st = bus.IMem_Ready ? 0 : 2;
                if (e_exen) m_bub = e_exfl;
                if (bus.Branch_Taken && !bus.IMem_Ready) m_pend = 1;
                else if (bus.IMem_Ready && e_ifen) m_pend = 0;
            end
        end

    task automatic chk(input string n, input logic [15:0] a, input logic [15:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", n, $time, a, e);
        end
    endtask

    always @(negedge clk)
        if (!rst) begin
            chk("m_PC_En", 16'(bus.PC_En), 16'(e_pc));
            chk("m_IFid_En", 16'(bus.IFid_En), 16'(e_ifen));
            chk("m_IFid_Flush", 16'(bus.IFid_Flush), 16'(e_iffl));
            chk("m_IDex_En", 16'(bus.IDex_En), 16'(e_iden));
            chk("m_IDex_Flush", 16'(bus.IDex_Flush), 16'(e_idfl));
            chk("m_EXmem_En", 16'(bus.EXmem_En), 16'(e_exen));
            chk("m_EXmem_Flush", 16'(bus.EXmem_Flush), 16'(e_exfl));
            chk("m_MEMwb_En", 16'(bus.MEMwb_En), 16'(e_wben));
            chk("m_BubbleMA", 16'(bus.BubbleMA), 16'(m_bub));
            chk("m_Mem_Err", 16'(bus.Mem_Err), 16'(m_err));
            chk("m_State", 16'(bus.State), 16'(m_st));
        end

    task automatic drive(input bit ns, bt, jp, imr, dq, dr, h);
        @(posedge clk);
        #1;
        {bus.Need_Stall, bus.Branch_Taken, bus.Jump_ID, bus.IMem_Ready, bus.DMem_Req, bus.DMem_Ready, bus.Halt} =
            {ns, bt, jp, imr, dq, dr, h};
        #2;
    endtask

    task automatic idle();
        drive(0, 0, 0, 1, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        #1 rst = 1'b0;
    endtask

    initial begin
        {bus.Need_Stall, bus.Branch_Taken, bus.Jump_ID, bus.DMem_Req, bus.DMem_Ready, bus.Halt} = '0;
        bus.IMem_Ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rst_State", 16'(bus.State), 16'd0);
        chk("rst_BubbleMA", 16'(bus.BubbleMA), 16'd0);
        chk("rst_Mem_Err", 16'(bus.Mem_Err), 16'd0);
        chk("rst_enables", 16'({bus.PC_En, bus.IFid_En, bus.IDex_En, bus.EXmem_En, bus.MEMwb_En}), 16'h1f);
        chk("rst_flushes", 16'({bus.IFid_Flush, bus.IDex_Flush, bus.EXmem_Flush}), 16'h0);
        // load-use
        drive(1, 0, 0, 1, 0, 0, 0);
        chk("lu_en", 16'({bus.PC_En, bus.IFid_En, bus.IDex_En, bus.EXmem_En, bus.MEMwb_En}), 16'h03);
        chk("lu_exfl", 16'(bus.EXmem_Flush), 16'd1);
        idle();
        chk("lu_bub1", 16'(bus.BubbleMA), 16'd1);
        idle();
        chk("lu_bub0", 16'(bus.BubbleMA), 16'd0);
        // branch with load-use
        drive(1, 1, 0, 1, 0, 0, 0);
        chk("br_fl", 16'({bus.IFid_Flush, bus.IDex_Flush, bus.EXmem_Flush}), 16'h6);
        chk("br_en", 16'({bus.PC_En, bus.IFid_En, bus.IDex_En, bus.EXmem_En, bus.MEMwb_En}), 16'h1f);
        idle();
        chk("br_bub", 16'(bus.BubbleMA), 16'd0);
        drive(0, 0, 1, 1, 0, 0, 0);
        chk("jmp_fl", 16'({bus.IFid_Flush, bus.IDex_Flush}), 16'h2);
        // data wait 3 cycles
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 1, 1, 0, 0);
            chk("dw_en", 16'({bus.PC_En, bus.IFid_En, bus.IDex_En, bus.EXmem_En, bus.MEMwb_En}), 16'h00);
            chk("dw_state", 16'(bus.State), (i == 0) ? 16'd0 : 16'd1);
        end
        drive(0, 0, 0, 1, 1, 1, 0);
        chk("dw_adv", 16'({bus.PC_En, bus.MEMwb_En}), 16'h3);
        idle();
        chk("dw_run", 16'(bus.State), 16'd0);
        // bubble holds across a freeze, stall re-evaluated on release
        drive(1, 0, 0, 1, 0, 0, 0);
        drive(1, 0, 0, 1, 1, 0, 0);
        chk("fz_bub", 16'(bus.BubbleMA), 16'd1);
        chk("fz_exfl", 16'(bus.EXmem_Flush), 16'd0);
        drive(1, 0, 0, 1, 1, 0, 0);
        chk("fz_bub2", 16'(bus.BubbleMA), 16'd1);
        drive(1, 0, 0, 1, 1, 1, 0);
        chk("fz_rel", 16'({bus.PC_En, bus.EXmem_Flush}), 16'h1);
        idle();
        chk("fz_bub3", 16'(bus.BubbleMA), 16'd1);
        idle();
        // fetch wait with redirect
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("iw_ctl", 16'({bus.PC_En, bus.IFid_En, bus.IFid_Flush, bus.IDex_Flush}), 16'h1);
        drive(0, 1, 0, 0, 0, 0, 0);
        chk("iw_br", 16'({bus.PC_En, bus.IFid_Flush, bus.State}), 16'h12);
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("iw_hold", 16'(bus.IFid_Flush), 16'd0);
        drive(0, 0, 0, 1, 0, 0, 0);
        chk("iw_rdy", 16'(bus.IFid_Flush), 16'd1);
        idle();
        chk("iw_clr", 16'(bus.IFid_Flush), 16'd0);
        // timeout
        for (int i = 0; i < MEM_TIMEOUT; i++) drive(0, 0, 0, 1, 1, 0, 0);
        idle();
        chk("to_state", 16'(bus.State), 16'd4);
        chk("to_err", 16'(bus.Mem_Err), 16'd1);
        chk("to_en", 16'(bus.PC_En), 16'd0);
        idle();
        chk("to_hold", 16'({bus.Mem_Err, bus.State}), 16'hc);
        do_reset();
        chk("to_rst", 16'({bus.Mem_Err, bus.State}), 16'h0);
        // async reset mid-DWAIT
        drive(0, 0, 0, 1, 1, 0, 0);
        drive(0, 0, 0, 1, 1, 0, 0);
        chk("ar_pre", 16'(bus.State), 16'd1);
        rst = 1'b1;
        #1;
        chk("ar_state", 16'(bus.State), 16'd0);
        chk("ar_err", 16'({bus.Mem_Err, bus.BubbleMA}), 16'd0);
        rst = 1'b0;
        idle();
        // halt
        drive(0, 0, 0, 1, 0, 0, 1);
        chk("h_en", 16'({bus.PC_En, bus.MEMwb_En}), 16'h1);
        idle();
        chk("h_state", 16'(bus.State), 16'd3);
        chk("h_en2", 16'({bus.PC_En, bus.MEMwb_En}), 16'h0);
        idle();
        do_reset();
        idle();
        chk("end_state", 16'(bus.State), 16'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
